credential_entry_ctrl: RTL
==========================

Name: credential_entry_ctrl

Overview:
- Front-end sequencer for the unlocker. Collects keypad digits, arbitrates the five command buttons and drives the unlocker's inputCount, userNameInput0-3, passwordInput0-3 and btn1-5 inputs in order.
- Watches the unlocker's lock output after each login attempt. Counts failed logins and imposes a timed lockout.
- Sits between the debounced board I/O and the unlocker instance.

Parameters:
DIGIT_W, 5, width of one digit; matches the unlocker's digit inputs
SETTLE_CYCLES, 4, cycles to wait after the final digit before sampling lock
MAX_FAILS, 3, consecutive failed logins that trigger lockout (1..15)
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles
TIMEOUT_CYCLES, 5000, idle cycles mid-entry before the entry aborts

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
digit_valid  in  1  one-cycle strobe; digit is valid
digit  in  DIGIT_W  keypad digit value
req_btn  in  5  command requests: [0]=logout, [1]=reset pw, [2]=add user, [3]=switch pw, [4]=delete user
lock  in  1  unlocker lock output (1 = locked)
inputCount  out  4  number of digits captured so far, 0..8
userNameInput0..3  out  DIGIT_W each  captured username digits
passwordInput0..3  out  DIGIT_W each  captured password digits
btn_out  out  5  one-hot command driven to unlocker btn1..btn5
busy  out  1  entry or command in progress
lockout  out  1  lockout active; all input ignored
fail_count  out  4  consecutive failed logins

Behaviour:
- Reset (async, any state): state=IDLE. inputCount, all digit outputs, btn_out, busy, lockout and fail_count are 0. Any in-flight entry is discarded.
- States: IDLE, CMD, ENTER_USER, ENTER_PASS, SETTLE, LOCKOUT.
- IDLE:
  - A req_btn set bit takes priority over digit_valid. Button priority is logout > delete > switch > add > reset.
  - On a button: latch one-hot btn_out, clear inputCount to 0, then go to CMD (logout) or ENTER_USER (all other commands).
  - On digit_valid with no button: plain login. Capture the digit into userNameInput0, set inputCount=1, go to ENTER_USER.
- CMD (logout): hold btn_out for exactly 10 cycles, then drop it and return to IDLE. fail_count is unchanged.
- ENTER_USER:
  - Each digit_valid writes userNameInput[inputCount] and increments inputCount in the same edge.
  - At inputCount=4:
    - reset-pw or delete command: go to SETTLE.
    - otherwise: go to ENTER_PASS.
- ENTER_PASS:
  - Each digit_valid writes passwordInput[inputCount-4] and increments inputCount.
  - At 8: go to SETTLE.
- btn_out stays asserted through ENTER_USER, ENTER_PASS and SETTLE. It drops on exit to IDLE.
- Digits captured in states other than ENTER_USER/ENTER_PASS are dropped. req_btn is ignored outside IDLE.
- SETTLE:
  - Count SETTLE_CYCLES, then sample lock.
  - Plain login only:
    - lock=0: clear fail_count.
    - lock=1: increment fail_count (saturating at 15).
  - If fail_count reaches MAX_FAILS, go to LOCKOUT. Otherwise return to IDLE.
  - Command entries do not touch fail_count.
  - On return to IDLE, inputCount stays at its final value until the next entry starts.
- LOCKOUT: lockout=1 for LOCKOUT_CYCLES. Then clear fail_count and return to IDLE. digit_valid and req_btn are ignored.
- Digit values are stored unmodified; there is no range check.
- busy=1 in every state except IDLE and LOCKOUT.

Optional Feature:
ENTRY_TIMEOUT_EN:
- Defined: a counter reloads on every accepted digit. If TIMEOUT_CYCLES elapse with no digit in ENTER_USER or ENTER_PASS:
  - inputCount goes to 0, btn_out to 0 and state to IDLE.
  - Digit registers keep their values; fail_count is unchanged.
  - A timeout arriving in the same cycle as digit_valid loses: the digit is accepted.
- Undefined: no timeout; an entry waits indefinitely.

Test Plan:
- Login 0,0,1,1 / 0,0,1,1 with lock falling to 0 within 2 cycles -> inputCount steps 1..8 one per strobe; fail_count stays 0; busy=0 after SETTLE_CYCLES.
- Three logins 0,0,1,1 / 0,1,1,0 with lock held 1 -> fail_count 1,2,3; lockout=1 for exactly 1000 cycles; digits ignored during lockout; then fail_count=0.
- req_btn=5'b00001 -> btn_out[0]=1 for exactly 10 cycles; inputCount=0; a digit strobe during this window is ignored.
- req_btn=5'b10010 in one cycle -> delete wins (btn_out=5'b10000); entry ends after 4 username digits 1,2,3,4; passwordInput0..3 unchanged.
- Assert rst mid-password with inputCount=6 -> all outputs 0 immediately, without waiting for a clock edge.
- ENTRY_TIMEOUT_EN defined: 2 digits then 5000 idle cycles -> inputCount=0, state IDLE; repeat with a digit at cycle 4999 -> entry continues with inputCount=3.

Source files
------------

// File: rtl/credential_entry_ctrl.sv
// Keypad/button front-end for the unlocker: sequences digit entry and commands, tracks failed logins.
// Optional macro ENTRY_TIMEOUT_EN aborts an entry left idle for TIMEOUT_CYCLES.
module credential_entry_ctrl #(
    parameter int DIGIT_W        = 5,
    parameter int SETTLE_CYCLES  = 4,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic [4:0]         req_btn,
    input  logic               lock,
    output logic [3:0]         inputCount,
    output logic [DIGIT_W-1:0] userNameInput0,
    output logic [DIGIT_W-1:0] userNameInput1,
    output logic [DIGIT_W-1:0] userNameInput2,
    output logic [DIGIT_W-1:0] userNameInput3,
    output logic [DIGIT_W-1:0] passwordInput0,
    output logic [DIGIT_W-1:0] passwordInput1,
    output logic [DIGIT_W-1:0] passwordInput2,
    output logic [DIGIT_W-1:0] passwordInput3,
    output logic [4:0]         btn_out,
    output logic               busy,
    output logic               lockout,
    output logic [3:0]         fail_count
);

    localparam int CMD_CYCLES = 10;
    localparam int TMR_A      = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_MAX    = (TMR_A > SETTLE_CYCLES + CMD_CYCLES) ? TMR_A : SETTLE_CYCLES + CMD_CYCLES;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] CMD_LAST    = TMR_W'(CMD_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef ENTRY_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE, CMD, ENTER_USER, ENTER_PASS, SETTLE, LOCKOUT
    } state_t;

    state_t                      state_q, state_d;
    logic [3:0]                  cnt_q, cnt_d;
    logic [3:0][DIGIT_W-1:0]     user_q, user_d;
    logic [3:0][DIGIT_W-1:0]     pass_q, pass_d;
    logic [4:0]                  btn_q, btn_d;
    logic [3:0]                  fail_q, fail_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [3:0]                  fail_next;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Logout outranks delete > switch > add > reset-pw.
    function automatic logic [4:0] pick_btn(input logic [4:0] req);
        if (req[0])      return 5'b00001;
        else if (req[4]) return 5'b10000;
        else if (req[3]) return 5'b01000;
        else if (req[2]) return 5'b00100;
        else             return 5'b00010;
    endfunction

    assign fail_next = lock ? sat_inc(fail_q) : 4'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        user_d  = user_q;
        pass_d  = pass_q;
        btn_d   = btn_q;
        fail_d  = fail_q;
        timer_d = timer_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (|req_btn) begin
                    btn_d   = pick_btn(req_btn);
                    cnt_d   = 4'd0;
                    state_d = req_btn[0] ? CMD : ENTER_USER;
                end else if (digit_valid) begin
                    user_d[0] = digit;
                    cnt_d     = 4'd1;
                    state_d   = ENTER_USER;
                end
            end
            CMD: begin
                if (timer_q == CMD_LAST) begin
                    btn_d   = 5'b0;
                    state_d = IDLE;
                end
            end
            ENTER_USER, ENTER_PASS: begin
`ifdef ENTRY_TIMEOUT_EN
                if (!digit_valid && timer_q == TO_LAST) begin
                    cnt_d   = 4'd0;
                    btn_d   = 5'b0;
                    state_d = IDLE;
                end
`else
                timer_d = '0;
`endif
                if (digit_valid) begin
                    timer_d = '0;
                    cnt_d   = cnt_q + 4'd1;
                    if (state_q == ENTER_USER) begin
                        user_d[cnt_q[1:0]] = digit;
                        // Reset-pw and delete carry only a username.
                        if (cnt_q == 4'd3)
                            state_d = (btn_q[1] | btn_q[4]) ? SETTLE : ENTER_PASS;
                    end else begin
                        pass_d[cnt_q[1:0]] = digit;
                        if (cnt_q == 4'd7)
                            state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (timer_q == SETTLE_LAST) begin
                    timer_d = '0;
                    btn_d   = 5'b0;
                    state_d = IDLE;
                    if (btn_q == 5'b0) begin
                        fail_d = fail_next;
                        if (fail_next >= 4'(MAX_FAILS))
                            state_d = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_q == LOCK_LAST) begin
                    fail_d  = 4'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            user_q  <= '0;
            pass_q  <= '0;
            btn_q   <= 5'b0;
            fail_q  <= 4'd0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            user_q  <= user_d;
            pass_q  <= pass_d;
            btn_q   <= btn_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
        end
    end

    assign inputCount     = cnt_q;
    assign userNameInput0 = user_q[0];
    assign userNameInput1 = user_q[1];
    assign userNameInput2 = user_q[2];
    assign userNameInput3 = user_q[3];
    assign passwordInput0 = pass_q[0];
    assign passwordInput1 = pass_q[1];
    assign passwordInput2 = pass_q[2];
    assign passwordInput3 = pass_q[3];
    assign btn_out        = btn_q;
    assign busy           = (state_q != IDLE) && (state_q != LOCKOUT);
    assign lockout        = (state_q == LOCKOUT);
    assign fail_count     = fail_q;

endmodule
